pattern_datapath: RTL
=====================

Name: pattern_datapath

Overview:
- Pixel datapath directly downstream of the pattern control FSM.
- Consumes its enables, select and mode strobes, and produces the 12-bit pattern pixel stream.
- Returns the endLine/endFrame status the FSM uses for line and frame sequencing.
- Holds the column counter (12-bit), row counter (5-bit), ramp row-base register and pixel accumulator with binary/Gray output coding.

Parameters:
DATA_W, 12, pixel width; all pixel arithmetic is modulo 2^DATA_W
TEST_LEN, 1290, pixels per line in test modes (BinaryOrGray=0)
NORMAL_LEN, 4096, pixels per line in regular mode (BinaryOrGray=1)
ROWS, 32, lines per frame; row counter width is 5 bits

Ports:
clk  in  1  16ns master clock
rst_n  in  1  asynchronous active-low reset
b12_enb  in  1  column counter enable
b5_enb  in  1  row counter enable
cnt_enb  in  1  accumulator advance enable
ramp_enb  in  1  ramp base update enable
newLine  in  1  line start strobe; loads accumulator, clears column counter
BinaryOrGray  in  1  1 = Gray-coded output and NORMAL_LEN; 0 = binary output and TEST_LEN
delta  in  1  add deltaY to ramp base (one pulse per line)
Xmode  in  2  per-pixel step: 00=0, 01=1, 10=4, 11=8
ValSel  in  2  source select: 00 ramp base, 01 const_val, 10 all-ones, 11 accumulator
const_val  in  12  user constant for CONSTANT mode
deltaY  in  12  ramp row increment
pixel  out  12  registered pixel
pix_valid  out  1  pixel qualifier
endLine  out  1  one-cycle pulse on the last pixel of a line
endFrame  out  1  level; high while row_cnt == ROWS-1

Behaviour:
- Reset values (asynchronous): pixel=0, pix_valid=0, endLine=0, endFrame=0, col_cnt=0, row_cnt=0, acc=0, ramp_base=0, active=0.
- Source value src:
  - ValSel 00 -> ramp_base
  - ValSel 01 -> const_val
  - ValSel 10 -> 12'hFFF
  - ValSel 11 -> acc + step(Xmode)
- newLine=1:
  - acc <= src, except ValSel=11 loads ramp_base.
  - col_cnt <= 0; active <= 1.
  - newLine has priority over every other update in the same cycle.
- Active cycle (active & cnt_enb & ~newLine):
  - acc <= src, so checkerboard selection changes take effect the next cycle.
  - Accumulator wraps 4095 -> 0 (ramp step 8 from 4092 gives 4).
- Column counter: increments when active & b12_enb. len = BinaryOrGray ? NORMAL_LEN : TEST_LEN.
- End of line: when col_cnt == len-1 and the column counter increments:
  - endLine pulses for one cycle and active <= 0.
  - col_cnt holds at len-1 until the next newLine.
- Row counter: increments on endLine when b5_enb=1; wraps 31 -> 0 after the last line.
  - endFrame is combinationally decoded from registered row_cnt.
  - The FSM sees endFrame & endLine together on the final pixel of the frame.
- Ramp base:
  - On delta & ramp_enb: ramp_base <= ramp_base + deltaY (mod 4096).
  - Cleared when row_cnt wraps to 0.
  - delta without ramp_enb is ignored.
- Output coding: pixel <= BinaryOrGray ? acc ^ (acc >> 1) : acc, registered.
- Latency:
  - pixel and pix_valid lag acc by 1 cycle; pix_valid = active delayed 1 cycle.
  - First valid pixel appears 2 cycles after newLine.
- Enables low (IDLE): all registers hold; endLine=0.
- Simultaneous newLine and endLine condition: newLine wins, so the line restarts and no endLine pulse is issued.
- Reset mid-line: returns everything to reset values immediately; no partial endLine.

Optional Feature:
- Macro: PATTERN_PARITY_EN.
- When defined:
  - Adds output pix_parity (1 bit): registered even parity of pixel, aligned with pixel (same cycle).
  - Adds sticky output parity_err, set when an internal recompute of pixel parity disagrees; cleared only by rst_n.
- When undefined: neither port exists and there is no parity logic.

Test Plan:
- Regular mode: BinaryOrGray=1, ValSel=11, Xmode=01, newLine pulse -> pixel 0,1,3,2,6... (Gray of 0..4095); endLine on the 4096th pixel; pix_valid high for exactly 4096 cycles.
- Constant: ValSel=01, const_val=12'hA5C, BinaryOrGray=0 -> 1290 pixels of 0xA5C; endLine pulse 1 cycle after the last column increment.
- Checkerboard: ValSel toggling 00/10 each cycle, ramp_base=0 -> pixel alternates 0x000/0xFFF; 2x2 pattern (toggle every 2 cycles) -> 0,0,FFF,FFF.
- Ramp: Xmode=11, deltaY=16, ramp_enb=1, delta pulsed per line -> line0 starts 0 then 8,16,...; line1 starts 16; wrap 4092+8 -> 4.
- Frame end: 32 lines with b5_enb=1 -> endFrame high during line 31; endFrame & endLine coincide on the final pixel; row_cnt and ramp_base return to 0.
- Async reset asserted mid-line at col_cnt=500 -> all outputs 0 immediately; after release, no output until the next newLine.

Source files
------------

// File: rtl/pattern_if.sv
// pattern_if: control/status bundle between the pattern FSM (master) and pattern_datapath (slave).
// PATTERN_PARITY_EN adds the pix_parity/parity_err status pair.
interface pattern_if #(parameter int DATA_W = 12);
  logic b12_enb, b5_enb, cnt_enb, ramp_enb, newLine, BinaryOrGray, delta;
  logic [1:0] Xmode, ValSel;
  logic [DATA_W-1:0] const_val, deltaY, pixel;
  logic pix_valid, endLine, endFrame;
`ifdef PATTERN_PARITY_EN
  logic pix_parity, parity_err;
`endif
  modport master(
    output b12_enb, b5_enb, cnt_enb, ramp_enb, newLine, BinaryOrGray, delta, Xmode, ValSel, const_val, deltaY,
`ifdef PATTERN_PARITY_EN
    input pix_parity, parity_err,
`endif
    input pixel, pix_valid, endLine, endFrame
  );
  modport slave(
    input b12_enb, b5_enb, cnt_enb, ramp_enb, newLine, BinaryOrGray, delta, Xmode, ValSel, const_val, deltaY,
`ifdef PATTERN_PARITY_EN
    output pix_parity, parity_err,
`endif
    output pixel, pix_valid, endLine, endFrame
  );
endinterface

// File: rtl/pattern_datapath.sv
// pattern_datapath: column/row counters, ramp base and pixel accumulator producing the pattern pixel stream.
// Optional PATTERN_PARITY_EN adds registered pixel parity and a sticky parity error flag.
module pattern_datapath #(
  parameter int DATA_W     = 12,
  parameter int TEST_LEN   = 1290,
  parameter int NORMAL_LEN = 4096,
  parameter int ROWS       = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  pattern_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  logic [11:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DATA_W-1:0] acc, ramp_base, step, src, coded;
  logic active, col_inc, col_last, row_last;
  always_comb begin
    step = bus.Xmode[1] ? (bus.Xmode[0] ? DATA_W'(8) : DATA_W'(4)) : (bus.Xmode[0] ? DATA_W'(1) : '0);
    src = bus.ValSel == 2'b00 ? ramp_base :
          bus.ValSel == 2'b01 ? bus.const_val :
          bus.ValSel == 2'b10 ? '1 : acc + step;
    col_inc = active & bus.b12_enb & ~bus.newLine;
    col_last = col_cnt == (bus.BinaryOrGray ? 12'(NORMAL_LEN - 1) : 12'(TEST_LEN - 1));
    row_last = row_cnt == RW'(ROWS - 1);
    coded = bus.BinaryOrGray ? acc ^ (acc >> 1) : acc;
  end
  assign bus.endFrame = row_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ramp_base <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      active <= 1'b0;
      bus.pixel <= '0;
      bus.pix_valid <= 1'b0;
      bus.endLine <= 1'b0;
    end else begin
      if (bus.newLine) begin
        acc <= bus.ValSel == 2'b11 ? ramp_base : src;
        col_cnt <= '0;
        active <= 1'b1;
      end else begin
        if (active & bus.cnt_enb) acc <= src;
        // the last column parks the counter and closes the line until the next newLine
        if (col_inc) begin
          if (col_last) active <= 1'b0;
          else col_cnt <= col_cnt + 12'd1;
        end
      end
      bus.endLine <= col_inc & col_last;
      if (bus.endLine & bus.b5_enb) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
      if (bus.endLine & bus.b5_enb & row_last) ramp_base <= '0;
      else if (bus.delta & bus.ramp_enb) ramp_base <= ramp_base + bus.deltaY;
      bus.pixel <= coded;
      bus.pix_valid <= active;
    end
`ifdef PATTERN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.pix_parity <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.pix_parity <= ^coded;
      if (bus.pix_parity != ^bus.pixel) bus.parity_err <= 1'b1;
    end
`endif
endmodule
